dram_ctrl: RTL and testbench

Data-memory stage directly downstream of the matrix-multiply processor. It owns the 256x8 data RAM that serves the processor's DRAM_addr/DRAM_dataOut/memREAD/memWRITE bus. It also gives a host/loader port a command interface to preload operand matrices, start the processor, and stream result matrices back out. A single FSM arbitrates between the host and the processor, so only one master touches the RAM at a time.

---
 rtl/proc_param.sv | 16 +
 rtl/dram_sp.sv | 38 +++
 rtl/dram_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_dram_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_param.sv
// Shared encodings for the data-memory stage: controller states and host command opcodes.
package proc_param;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DUMP  = 3'd2,
    ST_RUN   = 3'd3,
    ST_CLEAR = 3'd4
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_DUMP = 2'd1;
  localparam logic [1:0] OP_RUN  = 2'd2;

endpackage

// File: rtl/dram_sp.sv
// Single-port synchronous RAM with a registered read port; a write cycle leaves dout untouched.
module dram_sp #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout
);

  logic [WIDTH-1:0] mem_r [2**ADDR_W];
  logic [WIDTH-1:0] dout_r;

  // Storage array: contents survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= din;
    end
  end

  // Read register: only a pure read cycle updates it, so it holds between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_r <= '0;
    end else if (re && !we) begin
      dout_r <= mem_r[addr];
    end else begin
      dout_r <= dout_r;
    end
  end

  assign dout = dout_r;

endmodule

// File: rtl/dram_ctrl.sv
// Data-memory controller: one FSM arbitrates the data RAM between the host command port and the processor.
// Optional build macro MEM_CLEAR_EN zeroes the whole RAM after every reset before commands are accepted.
module dram_ctrl
  import proc_param::*;
#(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [ADDR_W-1:0] DRAM_addr,
  input  logic [WIDTH-1:0]  DRAM_dataOut,
  input  logic              memREAD,
  input  logic              memWRITE,
  output logic [WIDTH-1:0]  DRAM_dataIn,
  output logic              proc_en,
  input  logic              proc_done,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic              ld_valid,
  input  logic [WIDTH-1:0]  ld_data,
  output logic              ld_ready,
  output logic              dp_valid,
  output logic [WIDTH-1:0]  dp_data,
  input  logic              dp_ready,
  output logic              cmd_done,
  output logic              acc_err
);

  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] LEN_ZERO = {(ADDR_W+1){1'b0}};
`ifdef MEM_CLEAR_EN
  localparam state_t          RESET_ST = ST_CLEAR;
  localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W+1)'(DEPTH - 1);
`else
  localparam state_t          RESET_ST = ST_IDLE;
`endif

  state_t            state_r, state_nxt_s;
  logic [ADDR_W:0]   cnt_r, cnt_nxt_s, len_r;
  logic [ADDR_W-1:0] base_r;
  logic              latch_s, done_s, dp_valid_nxt_s;
  logic              cnt_last_s, ld_hs_s, dp_hs_s, stray_s;
  logic              cmd_ready_r, ld_ready_r, proc_en_r, dp_valid_r, cmd_done_r, acc_err_r;
  logic              ram_we_s, ram_re_s;
  logic [ADDR_W-1:0] ram_addr_s;
  logic [WIDTH-1:0]  ram_din_s, ram_dout_s;

  assign cnt_last_s = (cnt_r == (len_r - CNT_ONE));
  assign ld_hs_s    = ld_valid && ld_ready_r;
  assign dp_hs_s    = dp_valid_r && dp_ready;
  assign stray_s    = (memREAD || memWRITE) && (state_r != ST_RUN);

  // State, word counter and latched command fields
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r <= RESET_ST;
      cnt_r   <= '0;
      base_r  <= '0;
      len_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (latch_s) begin
        base_r <= cmd_base;
        len_r  <= cmd_len;
      end else begin
        base_r <= base_r;
        len_r  <= len_r;
      end
    end
  end

  // Next-state, counter and completion decode
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    latch_s        = 1'b0;
    done_s         = 1'b0;
    dp_valid_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_r) begin
          case (cmd_op)
            OP_LOAD, OP_DUMP: begin
              latch_s   = 1'b1;
              cnt_nxt_s = '0;
              if (cmd_len == LEN_ZERO) begin
                done_s = 1'b1;
              end else if (cmd_op == OP_LOAD) begin
                state_nxt_s = ST_LOAD;
              end else begin
                state_nxt_s = ST_DUMP;
              end
            end
            OP_RUN:  state_nxt_s = ST_RUN;
            default: state_nxt_s = ST_IDLE;
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (ld_hs_s) begin
          cnt_nxt_s = cnt_r + CNT_ONE;
          if (cnt_last_s) begin
            state_nxt_s = ST_IDLE;
            done_s      = 1'b1;
          end else begin
            state_nxt_s = ST_LOAD;
          end
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      // A word is read while dp_valid is low, then presented until taken
      ST_DUMP: begin
        if (!dp_valid_r) begin
          dp_valid_nxt_s = 1'b1;
        end else if (dp_hs_s) begin
          cnt_nxt_s = cnt_r + CNT_ONE;
          if (cnt_last_s) begin
            state_nxt_s = ST_IDLE;
            done_s      = 1'b1;
          end else begin
            state_nxt_s = ST_DUMP;
          end
        end else begin
          dp_valid_nxt_s = 1'b1;
        end
      end
      ST_RUN: begin
        if (proc_done) begin
          state_nxt_s = ST_IDLE;
          done_s      = 1'b1;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
`ifdef MEM_CLEAR_EN
      ST_CLEAR: begin
        if (cnt_r == CLR_LAST) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
`endif
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // RAM port mux: the state decides which master owns address, data and strobes
  always_comb begin
    ram_we_s   = 1'b0;
    ram_re_s   = 1'b0;
    ram_addr_s = base_r + cnt_r[ADDR_W-1:0];
    ram_din_s  = ld_data;
    case (state_r)
      ST_LOAD: ram_we_s = ld_hs_s;
      ST_DUMP: ram_re_s = !dp_valid_r;
      ST_RUN: begin
        ram_addr_s = DRAM_addr;
        ram_din_s  = DRAM_dataOut;
        ram_we_s   = memWRITE;
        ram_re_s   = memREAD && !memWRITE;
      end
`ifdef MEM_CLEAR_EN
      ST_CLEAR: begin
        ram_addr_s = cnt_r[ADDR_W-1:0];
        ram_din_s  = '0;
        ram_we_s   = 1'b1;
      end
`endif
      default: ram_we_s = 1'b0;
    endcase
  end

  // Registered handshake and status outputs
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cmd_ready_r <= 1'b1;
      ld_ready_r  <= 1'b0;
      proc_en_r   <= 1'b0;
      dp_valid_r  <= 1'b0;
      cmd_done_r  <= 1'b0;
      acc_err_r   <= 1'b0;
    end else begin
      cmd_ready_r <= (state_nxt_s == ST_IDLE);
      ld_ready_r  <= (state_nxt_s == ST_LOAD);
      proc_en_r   <= (state_nxt_s == ST_RUN);
      dp_valid_r  <= dp_valid_nxt_s;
      cmd_done_r  <= done_s;
      acc_err_r   <= acc_err_r || stray_s;
    end
  end

  dram_sp #(
    .WIDTH (WIDTH),
    .ADDR_W($clog2(DEPTH))
  ) u_ram (
    .clk  (Clk),
    .rst_n(Rst_n),
    .we   (ram_we_s),
    .re   (ram_re_s),
    .addr (ram_addr_s),
    .din  (ram_din_s),
    .dout (ram_dout_s)
  );

  assign DRAM_dataIn = ram_dout_s;
  assign dp_data     = ram_dout_s;
  assign dp_valid    = dp_valid_r;
  assign cmd_ready   = cmd_ready_r;
  assign ld_ready    = ld_ready_r;
  assign proc_en     = proc_en_r;
  assign cmd_done    = cmd_done_r;
  assign acc_err     = acc_err_r;

endmodule

// File: tb/tb_dram_ctrl.sv
// Self-checking bench for dram_ctrl: directed steps plus randomized traffic against an array model of the RAM.
module tb_dram_ctrl;
  import proc_param::*;

  logic       Clk, Rst_n;
  logic [7:0] DRAM_addr, DRAM_dataOut, DRAM_dataIn;
  logic       memREAD, memWRITE, proc_en, proc_done;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_base;
  logic [8:0] cmd_len;
  logic       ld_valid, ld_ready, dp_valid, dp_ready, cmd_done, acc_err;
  logic [7:0] ld_data, dp_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem_m [256];
  bit         known_m [256];
  logic [7:0] ld_buf [256];
  bit         acc_exp;

  dram_ctrl dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .DRAM_addr(DRAM_addr), .DRAM_dataOut(DRAM_dataOut),
    .memREAD(memREAD), .memWRITE(memWRITE), .DRAM_dataIn(DRAM_dataIn),
    .proc_en(proc_en), .proc_done(proc_done),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_base(cmd_base), .cmd_len(cmd_len),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .dp_valid(dp_valid), .dp_data(dp_data), .dp_ready(dp_ready),
    .cmd_done(cmd_done), .acc_err(acc_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clear();
`ifdef MEM_CLEAR_EN
    int guard = 0;
    while (cmd_ready !== 1'b1 && guard < 400) begin
      tick();
      guard++;
    end
    check("clear_finishes", cmd_ready, 1);
    check("clear_no_done", cmd_done, 0);
    for (int k = 0; k < 256; k++) begin
      mem_m[k]   = 8'h00;
      known_m[k] = 1'b1;
    end
`endif
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] base, input int len);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_base  = base;
    cmd_len   = 9'(len);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] base, input int len, input bit gaps);
    int idx = 0;
    int guard = 0;
    bit hs;
    logic [7:0] a;
    send_cmd(OP_LOAD, base, len);
    if (len == 0) begin
      check("load0_done", cmd_done, 1);
      check("load0_idle", cmd_ready, 1);
      check("load0_no_ready", ld_ready, 0);
      tick();
      check("load0_done_pulse", cmd_done, 0);
      return;
    end
    while (idx < len && guard < 4 * len + 20) begin
      check("load_ready", ld_ready, 1);
      check("load_busy", cmd_ready, 0);
      ld_valid  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      ld_data   = ld_buf[idx];
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = OP_RUN;
      hs        = ld_valid;
      tick();
      guard++;
      if (hs) begin
        a = base + 8'(idx);
        mem_m[a]   = ld_buf[idx];
        known_m[a] = 1'b1;
        idx++;
      end
    end
    ld_valid  = 1'b0;
    cmd_valid = 1'b0;
    if (idx < len) check("load_timeout", 0, 1);
    check("load_done", cmd_done, 1);
    check("load_ready_drop", ld_ready, 0);
    check("load_idle", cmd_ready, 1);
    tick();
    check("load_done_pulse", cmd_done, 0);
    check("load_stray_cmd", proc_en, 0);
  endtask

  task automatic do_dump(input logic [7:0] base, input int len, input bit stall_first);
    int i = 0;
    int guard = 0;
    bit prev_hs = 1'b0;
    logic [7:0] a;
    send_cmd(OP_DUMP, base, len);
    if (len == 0) begin
      check("dump0_done", cmd_done, 1);
      check("dump0_idle", cmd_ready, 1);
      check("dump0_no_valid", dp_valid, 0);
      tick();
      check("dump0_done_pulse", cmd_done, 0);
      return;
    end
    check("dump_busy", cmd_ready, 0);
    check("dump_first_lat", dp_valid, 0);
    tick();
    check("dump_valid_rise", dp_valid, 1);
    if (stall_first) begin
      dp_ready = 1'b0;
      for (int s = 0; s < 5; s++) begin
        tick();
        check("stall_valid", dp_valid, 1);
        if (known_m[base]) check("stall_data", dp_data, mem_m[base]);
      end
    end
    while (i < len && guard < 4 * len + 20) begin
      if (prev_hs) check("dump_gap", dp_valid, 0);
      dp_ready = ($urandom_range(0, 3) != 0);
      prev_hs  = 1'b0;
      if (dp_valid === 1'b1) begin
        a = base + 8'(i);
        if (known_m[a]) check("dump_data", dp_data, mem_m[a]);
        if (dp_ready) begin
          i++;
          prev_hs = 1'b1;
        end
      end
      tick();
      guard++;
    end
    dp_ready = 1'b0;
    if (i < len) check("dump_timeout", 0, 1);
    check("dump_done", cmd_done, 1);
    check("dump_valid_low", dp_valid, 0);
    check("dump_idle", cmd_ready, 1);
    tick();
    check("dump_done_pulse", cmd_done, 0);
  endtask

  task automatic start_run();
    send_cmd(OP_RUN, 8'h00, 0);
    check("run_proc_en", proc_en, 1);
    check("run_busy", cmd_ready, 0);
    check("run_no_ld_ready", ld_ready, 0);
  endtask

  task automatic run_rw(input logic [7:0] a, input logic [7:0] d);
    memWRITE = 1'b1;
    DRAM_addr = a;
    DRAM_dataOut = d;
    tick();
    memWRITE = 1'b0;
    mem_m[a]   = d;
    known_m[a] = 1'b1;
    memREAD = 1'b1;
    tick();
    memREAD = 1'b0;
    check("run_read", DRAM_dataIn, mem_m[a]);
    DRAM_addr = ~a;
    tick();
    check("run_read_hold", DRAM_dataIn, mem_m[a]);
  endtask

  task automatic end_run();
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    check("run_en_drop", proc_en, 0);
    check("run_done", cmd_done, 1);
    check("run_idle", cmd_ready, 1);
    check("run_acc_err", acc_err, acc_exp);
    tick();
    check("run_done_pulse", cmd_done, 0);
  endtask

  initial begin
    logic [7:0] last_b;
    int         last_l;
    Rst_n = 1'b0;
    {memREAD, memWRITE, proc_done, cmd_valid, ld_valid, dp_ready} = 6'b000000;
    DRAM_addr = 8'h00; DRAM_dataOut = 8'h00; cmd_op = 2'd0; cmd_base = 8'h00;
    cmd_len = 9'd0; ld_data = 8'h00;
    acc_exp = 1'b0;
    for (int k = 0; k < 256; k++) known_m[k] = 1'b0;

    // Reset values
    repeat (2) @(posedge Clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_proc_en", proc_en, 0);
    check("rst_dp_valid", dp_valid, 0);
    check("rst_cmd_done", cmd_done, 0);
    check("rst_acc_err", acc_err, 0);
    check("rst_dataIn", DRAM_dataIn, 0);
    Rst_n = 1'b1;
    tick();
    wait_clear();

    // Plan 1: load and dump four words
    ld_buf[0] = 8'h11; ld_buf[1] = 8'h22; ld_buf[2] = 8'h33; ld_buf[3] = 8'h44;
    do_load(8'h10, 4, 1'b0);
    do_dump(8'h10, 4, 1'b0);

    // Plan 2: wrap past the top address
    ld_buf[0] = 8'hA0; ld_buf[1] = 8'hA1; ld_buf[2] = 8'hA2;
    do_load(8'hFE, 3, 1'b1);
    do_dump(8'hFE, 3, 1'b0);
    do_dump(8'h00, 1, 1'b0);

    // Plan 3: consumer stall holds the first word
    do_dump(8'h10, 4, 1'b1);

    // Plan 4: processor write/read, write-wins collision, done
    start_run();
    run_rw(8'h30, 8'h5A);
    memWRITE = 1'b1; memREAD = 1'b1; DRAM_addr = 8'h31; DRAM_dataOut = 8'h77;
    tick();
    memWRITE = 1'b0; memREAD = 1'b0;
    mem_m[8'h31] = 8'h77; known_m[8'h31] = 1'b1;
    check("collide_keeps_data", DRAM_dataIn, 8'h5A);
    memREAD = 1'b1;
    tick();
    memREAD = 1'b0;
    check("collide_write_landed", DRAM_dataIn, 8'h77);
    end_run();

    // Plan 5: stray processor write in IDLE, zero-length commands, reserved op
    memWRITE = 1'b1; DRAM_addr = 8'h10; DRAM_dataOut = 8'hFF;
    tick();
    memWRITE = 1'b0;
    acc_exp = 1'b1;
    check("stray_acc_err", acc_err, 1);
    do_dump(8'h10, 1, 1'b0);
    do_load(8'h40, 0, 1'b0);
    do_dump(8'h40, 0, 1'b0);
    send_cmd(2'd3, 8'h00, 5);
    check("op3_idle", cmd_ready, 1);
    check("op3_no_done", cmd_done, 0);
    check("op3_no_load", ld_ready, 0);
    check("op3_no_run", proc_en, 0);
    check("acc_err_sticky", acc_err, 1);

    // Plan 6: reset in the middle of a load
    for (int k = 0; k < 8; k++) ld_buf[k] = 8'(8'hC0 + k);
    send_cmd(OP_LOAD, 8'h80, 8);
    ld_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ld_data = ld_buf[k];
      tick();
      mem_m[8'h80 + 8'(k)] = ld_buf[k];
      known_m[8'h80 + 8'(k)] = 1'b1;
    end
    ld_valid = 1'b0;
    Rst_n = 1'b0;
    #1;
    check("abort_ld_ready", ld_ready, 0);
    check("abort_cmd_ready", cmd_ready, 1);
    check("abort_no_done", cmd_done, 0);
    check("abort_acc_err", acc_err, 0);
    acc_exp = 1'b0;
    tick();
    Rst_n = 1'b1;
    tick();
    check("abort_still_no_done", cmd_done, 0);
    wait_clear();
    do_dump(8'h80, 3, 1'b0);
    do_dump(8'h10, 4, 1'b0);

    // Randomized mix of commands
    last_b = 8'h10;
    last_l = 4;
    for (int it = 0; it < 16; it++) begin
      logic [7:0] b;
      int l;
      b = 8'($urandom);
      l = $urandom_range(1, 6);
      case ($urandom_range(0, 3))
        0: begin
          for (int k = 0; k < l; k++) ld_buf[k] = 8'($urandom);
          do_load(b, l, 1'b1);
          last_b = b;
          last_l = l;
        end
        1: do_dump(last_b, last_l, 1'b0);
        2: begin
          start_run();
          for (int k = 0; k < 3; k++) run_rw(8'($urandom), 8'($urandom));
          end_run();
        end
        default: begin
          send_cmd(2'd3, b, l);
          check("rand_op3_idle", cmd_ready, 1);
          check("rand_op3_no_done", cmd_done, 0);
        end
      endcase
    end

    // Full-depth load and dump starting at a random base
    for (int k = 0; k < 256; k++) ld_buf[k] = 8'($urandom);
    last_b = 8'($urandom);
    do_load(last_b, 256, 1'b0);
    do_dump(last_b, 256, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
